multicycle_controlunit: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 57 +++++
 rtl/mips_opdecode.sv | 31 +++
 rtl/multicycle_controlunit.sv | 147 ++++++++++++++
 tb/tb_multicycle_controlunit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states,
// ALU operations, ALU B-source and next-PC source codes, decoded opcode classes.
package mips_ctrl_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_LW  = 4;
  localparam int OP_SW  = 5;
  localparam int OP_BEQ = 6;
  localparam int OP_BNE = 7;
  localparam int OP_J   = 8;
  localparam int OP_SLT = 9;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_TRAP    = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } aluop_e;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic illegal;
  } opclass_t;

endpackage

// File: rtl/mips_opdecode.sv
// Combinational opcode classifier: one-hot class flags plus the R-type ALU op.
// Zero latency; no flow control. Any value outside the ten defined opcodes is illegal.
module mips_opdecode
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output opclass_t       cls,
  output aluop_e         rtype_aluop
);

  always_comb begin
    cls         = '0;
    rtype_aluop = ALU_ADD;
    case (opcode)
      OPW'(OP_ADD): begin cls.rtype = 1'b1; rtype_aluop = ALU_ADD; end
      OPW'(OP_SUB): begin cls.rtype = 1'b1; rtype_aluop = ALU_SUB; end
      OPW'(OP_AND): begin cls.rtype = 1'b1; rtype_aluop = ALU_AND; end
      OPW'(OP_OR):  begin cls.rtype = 1'b1; rtype_aluop = ALU_OR;  end
      OPW'(OP_SLT): begin cls.rtype = 1'b1; rtype_aluop = ALU_SLT; end
      OPW'(OP_LW):  cls.lw  = 1'b1;
      OPW'(OP_SW):  cls.sw  = 1'b1;
      OPW'(OP_BEQ): cls.beq = 1'b1;
      OPW'(OP_BNE): cls.bne = 1'b1;
      OPW'(OP_J):   cls.j   = 1'b1;
      default:      cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controlunit.sv
// Multi-cycle MIPS control FSM: 3-5 cycles per instruction plus one per mem_ready=0 cycle.
// Memory stalls hold FETCH/MEMRD/MEMWR with strobes steady; illegal opcodes park in TRAP until reset.
module multicycle_controlunit
  import mips_ctrl_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              mem_ready,
  output logic              pcwrite,
  output logic              pcwritecond,
  output logic              pcwritebne,
  output logic              iord,
  output logic              memread,
  output logic              memwrite,
  output logic              irwrite,
  output logic              memtoreg,
  output logic              regdst,
  output logic              regwrite,
  output logic              alusrca,
  output logic [1:0]        alusrcb,
  output logic [ALUOPW-1:0] aluop,
  output logic [1:0]        pcsource,
  output logic              retire,
  output logic              illegal,
  output logic [3:0]        state
);

  state_e   state_q, state_d;
  opclass_t cls;
  aluop_e   rtype_aluop;
  aluop_e   alu_sel;

  mips_opdecode #(.OPW(OPW)) u_opdecode (
    .opcode      (opcode),
    .cls         (cls),
    .rtype_aluop (rtype_aluop)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Under reset every output is held low, including the debug state view.
  always_comb begin
    state_d     = state_q;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    pcwritebne  = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_RT;
    alu_sel     = ALU_ADD;
    pcsource    = PCS_ALU;
    retire      = 1'b0;
    illegal     = 1'b0;
    state       = '0;
    if (!reset) begin
      state = 4'(state_q);
      case (state_q)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = SRCB_FOUR;
          if (mem_ready) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          alusrcb = SRCB_IMMSH;
          if (cls.illegal)              state_d = S_TRAP;
          else if (cls.rtype)           state_d = S_EXEC;
          else if (cls.lw || cls.sw)    state_d = S_MEMADR;
          else if (cls.beq || cls.bne)  state_d = S_BRANCH;
          else                          state_d = S_JUMP;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          alu_sel = rtype_aluop;
          state_d = S_RTYPEWB;
        end
        S_RTYPEWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
          state_d = cls.lw ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEMWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_BRANCH: begin
          alusrca     = 1'b1;
          alu_sel     = ALU_SUB;
          pcsource    = PCS_ALUOUT;
          pcwritecond = cls.beq;
          pcwritebne  = cls.bne;
          retire      = 1'b1;
          state_d     = S_FETCH;
        end
        S_JUMP: begin
          pcwrite  = 1'b1;
          pcsource = PCS_JUMP;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_TRAP: begin
          illegal = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
    aluop = ALUOPW'(alu_sel);
  end

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Directed bench: every cycle compares the full packed output vector against a hand-written constant.
module tb_multicycle_controlunit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, pcwritebne, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, retire, illegal;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] aluop;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  multicycle_controlunit #(.OPW(6), .ALUOPW(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .pcwritebne(pcwritebne),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource), .retire(retire),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Layout: {pw pwc pwb iord mr mw irw m2r rd rw asa, alusrcb, aluop, pcsource, retire illegal, state}
  logic [23:0] outs;
  assign outs = {pcwrite, pcwritecond, pcwritebne, iord, memread, memwrite, irwrite,
                 memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
                 retire, illegal, state};

  localparam logic [23:0] ZERO       = 24'd0;
  localparam logic [23:0] FETCH_RDY  = {11'b10001010000, 2'b01, 3'b000, 2'b00, 2'b00, 4'd0};
  localparam logic [23:0] FETCH_WAIT = {11'b00001000000, 2'b01, 3'b000, 2'b00, 2'b00, 4'd0};
  localparam logic [23:0] DECODE     = {11'b00000000000, 2'b11, 3'b000, 2'b00, 2'b00, 4'd1};
  localparam logic [23:0] EXEC_ADD   = {11'b00000000001, 2'b00, 3'b000, 2'b00, 2'b00, 4'd6};
  localparam logic [23:0] EXEC_SUB   = {11'b00000000001, 2'b00, 3'b001, 2'b00, 2'b00, 4'd6};
  localparam logic [23:0] EXEC_SLT   = {11'b00000000001, 2'b00, 3'b100, 2'b00, 2'b00, 4'd6};
  localparam logic [23:0] RTYPEWB    = {11'b00000000110, 2'b00, 3'b000, 2'b00, 2'b10, 4'd7};
  localparam logic [23:0] MEMADR     = {11'b00000000001, 2'b10, 3'b000, 2'b00, 2'b00, 4'd2};
  localparam logic [23:0] MEMRD      = {11'b00011000000, 2'b00, 3'b000, 2'b00, 2'b00, 4'd3};
  localparam logic [23:0] MEMWB      = {11'b00000001010, 2'b00, 3'b000, 2'b00, 2'b10, 4'd4};
  localparam logic [23:0] MEMWR_RDY  = {11'b00010100000, 2'b00, 3'b000, 2'b00, 2'b10, 4'd5};
  localparam logic [23:0] MEMWR_WAIT = {11'b00010100000, 2'b00, 3'b000, 2'b00, 2'b00, 4'd5};
  localparam logic [23:0] BR_BEQ     = {11'b01000000001, 2'b00, 3'b001, 2'b01, 2'b10, 4'd8};
  localparam logic [23:0] BR_BNE     = {11'b00100000001, 2'b00, 3'b001, 2'b01, 2'b10, 4'd8};
  localparam logic [23:0] JUMP       = {11'b10000000000, 2'b00, 3'b000, 2'b10, 2'b10, 4'd9};
  localparam logic [23:0] TRAP       = {11'b00000000000, 2'b00, 3'b000, 2'b00, 2'b01, 4'd10};

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs are already set; compare mid-cycle, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [23:0] exp);
    #1;
    chk(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'd0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("reset_hold0", ZERO);
    cyc("reset_hold1", ZERO);
    reset = 1'b0;

    // add, no wait states: 4 cycles, retire only in the last
    cyc("add_fetch", FETCH_RDY);
    cyc("add_decode", DECODE);
    cyc("add_exec", EXEC_ADD);
    cyc("add_wb", RTYPEWB);

    // sub
    opcode = 6'd1;
    cyc("sub_fetch", FETCH_RDY);
    cyc("sub_decode", DECODE);
    cyc("sub_exec", EXEC_SUB);
    cyc("sub_wb", RTYPEWB);

    // lw with two wait states in MEMRD: 7 cycles
    opcode = 6'd4;
    cyc("lw_fetch", FETCH_RDY);
    cyc("lw_decode", DECODE);
    cyc("lw_memadr", MEMADR);
    mem_ready = 1'b0;
    cyc("lw_memrd_w0", MEMRD);
    cyc("lw_memrd_w1", MEMRD);
    mem_ready = 1'b1;
    cyc("lw_memrd_rdy", MEMRD);
    cyc("lw_memwb", MEMWB);

    // sw then bne back to back
    opcode = 6'd5;
    cyc("sw_fetch", FETCH_RDY);
    cyc("sw_decode", DECODE);
    cyc("sw_memadr", MEMADR);
    cyc("sw_memwr", MEMWR_RDY);
    opcode = 6'd7;
    cyc("bne_fetch", FETCH_RDY);
    cyc("bne_decode", DECODE);
    cyc("bne_branch", BR_BNE);

    // beq
    opcode = 6'd6;
    cyc("beq_fetch", FETCH_RDY);
    cyc("beq_decode", DECODE);
    cyc("beq_branch", BR_BEQ);

    // slt
    opcode = 6'd9;
    cyc("slt_fetch", FETCH_RDY);
    cyc("slt_decode", DECODE);
    cyc("slt_exec", EXEC_SLT);
    cyc("slt_wb", RTYPEWB);

    // j
    opcode = 6'd8;
    cyc("j_fetch", FETCH_RDY);
    cyc("j_decode", DECODE);
    cyc("j_jump", JUMP);

    // sw stalled one cycle in MEMWR: retire only once ready
    opcode = 6'd5;
    cyc("sww_fetch", FETCH_RDY);
    cyc("sww_decode", DECODE);
    cyc("sww_memadr", MEMADR);
    mem_ready = 1'b0;
    cyc("sww_memwr_w", MEMWR_WAIT);
    mem_ready = 1'b1;
    cyc("sww_memwr_rdy", MEMWR_RDY);

    // FETCH stalled: no IR/PC load
    opcode    = 6'd0;
    mem_ready = 1'b0;
    cyc("fetch_wait0", FETCH_WAIT);
    cyc("fetch_wait1", FETCH_WAIT);
    mem_ready = 1'b1;
    cyc("fetch_wait_rdy", FETCH_RDY);
    cyc("fetch_wait_decode", DECODE);
    cyc("fetch_wait_exec", EXEC_ADD);
    cyc("fetch_wait_wb", RTYPEWB);

    // reset during MEMRD aborts without retire
    opcode = 6'd4;
    cyc("rst_lw_fetch", FETCH_RDY);
    cyc("rst_lw_decode", DECODE);
    cyc("rst_lw_memadr", MEMADR);
    mem_ready = 1'b0;
    cyc("rst_lw_memrd", MEMRD);
    reset = 1'b1;
    cyc("rst_mid0", ZERO);
    cyc("rst_mid1", ZERO);
    reset     = 1'b0;
    mem_ready = 1'b1;
    cyc("rst_after_fetch", FETCH_RDY);
    cyc("rst_after_decode", DECODE);
    cyc("rst_after_memadr", MEMADR);
    cyc("rst_after_memrd", MEMRD);
    cyc("rst_after_memwb", MEMWB);

    // illegal opcode 0x2A: sticky TRAP regardless of inputs
    opcode = 6'h2A;
    cyc("ill_fetch", FETCH_RDY);
    cyc("ill_decode", DECODE);
    for (int i = 0; i < 12; i++) begin
      mem_ready = i[0];
      opcode    = (i < 6) ? 6'h2A : 6'd0;
      cyc("ill_trap_hold", TRAP);
    end
    reset     = 1'b1;
    mem_ready = 1'b1;
    cyc("ill_reset", ZERO);
    reset = 1'b0;
    cyc("ill_recover_fetch", FETCH_RDY);

    // first opcode past the legal range also traps
    opcode = 6'd10;
    cyc("op10_decode", DECODE);
    cyc("op10_trap0", TRAP);
    cyc("op10_trap1", TRAP);
    reset = 1'b1;
    cyc("op10_reset", ZERO);
    reset = 1'b0;
    cyc("op10_recover", FETCH_RDY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
